// File: rtl/sector_buf_pkg.sv
// Shared types and default widths for the ping-pong sector buffer.
package sector_buf_pkg;

  localparam int unsigned DEF_ADDR_W = 9;   // 512-byte sector per bank
  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_SECT_W = 16;  // packed cylinder/head/sector id

  typedef enum logic [1:0] {
    BankFree,
    BankFilling,
    BankPending,
    BankDraining
  } bank_state_t;

  typedef enum logic [1:0] {
    DrainIdle,
    DrainReq,
    DrainDrain
  } drain_state_t;

endpackage

// File: rtl/sector_ram.sv
// Two-bank sector RAM: capture write port, registered storage read port.
module sector_ram
  import sector_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_en,
  input  logic              i_wr_bank,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_bank,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int unsigned Depth = 2 * (1 << ADDR_W);

  logic [DATA_W-1:0] r_mem [Depth];
  logic [DATA_W-1:0] r_rd_data;

  // Capture write into the active bank; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
    end
  end

  // Registered read from the storage-side bank.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[{i_rd_bank, i_rd_addr}];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sector_flush_ctrl.sv
// Ping-pong sector buffer controller. Capture fills the active bank; each
// flush pulse swaps banks and offers the filled one to storage via
// req/ack/done. Optional build macro EMPTY_SKIP_EN suppresses swaps for
// flushes of an empty bank.
module sector_flush_ctrl
  import sector_buf_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned SECT_W = DEF_SECT_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_en,
  input  logic              i_wr_flush,
  input  logic [SECT_W-1:0] i_sector_id,
  output logic              o_flush_req,
  output logic [SECT_W-1:0] o_flush_sector,
  output logic [ADDR_W:0]   o_flush_len,
  input  logic              i_flush_ack,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_flush_done,
  output logic              o_busy,
  output logic              o_overrun
);

  localparam int unsigned LenW = ADDR_W + 1;

  bank_state_t       r_bank_state [2];
  bank_state_t       w_bank_state_nxt [2];
  drain_state_t      r_drain;
  drain_state_t      w_drain_nxt;
  logic              r_wr_bank;
  logic              w_wr_bank_nxt;
  logic              w_rd_bank;
  logic [LenW-1:0]   r_fill_len;
  logic [LenW-1:0]   w_fill_len_nxt;
  logic [LenW-1:0]   w_fill_upd;
  logic [LenW-1:0]   w_wr_end;
  logic [SECT_W-1:0] r_flush_sector;
  logic [SECT_W-1:0] w_flush_sector_nxt;
  logic [LenW-1:0]   r_flush_len;
  logic [LenW-1:0]   w_flush_len_nxt;
  logic              r_overrun;
  logic              w_overrun_nxt;
  logic              w_ack;
  logic              w_done;
  logic              w_other_free;
  logic              w_flush_eff;

  // Storage always reads the bank capture is not writing.
  assign w_rd_bank = ~r_wr_bank;

  // Highest written address + 1; max value 2^ADDR_W fits LenW, so no wrap.
  assign w_wr_end   = {1'b0, i_wr_addr} + LenW'(1);
  assign w_fill_upd = (i_wr_en && (w_wr_end > r_fill_len)) ? w_wr_end : r_fill_len;

  assign w_ack  = (r_drain == DrainReq) && i_flush_ack;
  assign w_done = (r_drain == DrainDrain) && i_flush_done;

  // A same-cycle done frees the draining bank before the swap decision.
  assign w_other_free = (r_bank_state[w_rd_bank] == BankFree) || w_done;

`ifdef EMPTY_SKIP_EN
  assign w_flush_eff = i_wr_flush && !((r_fill_len == '0) && !i_wr_en);
`else
  assign w_flush_eff = i_wr_flush;
`endif

  // Next-state: drain handshake first, then flush swap / overrun on top.
  always_comb begin
    w_bank_state_nxt   = r_bank_state;
    w_drain_nxt        = r_drain;
    w_wr_bank_nxt      = r_wr_bank;
    w_fill_len_nxt     = w_fill_upd;
    w_flush_sector_nxt = r_flush_sector;
    w_flush_len_nxt    = r_flush_len;
    w_overrun_nxt      = r_overrun;

    if (w_ack) begin
      w_drain_nxt                 = DrainDrain;
      w_bank_state_nxt[w_rd_bank] = BankDraining;
    end
    if (w_done) begin
      w_drain_nxt                 = DrainIdle;
      w_bank_state_nxt[w_rd_bank] = BankFree;
    end

    if (w_flush_eff) begin
      w_fill_len_nxt = '0;
      if (w_other_free) begin
        w_bank_state_nxt[r_wr_bank] = BankPending;
        w_bank_state_nxt[w_rd_bank] = BankFilling;
        w_wr_bank_nxt               = ~r_wr_bank;
        w_drain_nxt                 = DrainReq;
        w_flush_sector_nxt          = i_sector_id;
        w_flush_len_nxt             = w_fill_upd;
      end else begin
        // No swap: the next sector overwrites the active bank.
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // State register; reset abandons any in-flight drain.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bank_state[0] <= BankFilling;
      r_bank_state[1] <= BankFree;
      r_drain         <= DrainIdle;
      r_wr_bank       <= 1'b0;
      r_fill_len      <= '0;
      r_flush_sector  <= '0;
      r_flush_len     <= '0;
      r_overrun       <= 1'b0;
    end else begin
      r_bank_state    <= w_bank_state_nxt;
      r_drain         <= w_drain_nxt;
      r_wr_bank       <= w_wr_bank_nxt;
      r_fill_len      <= w_fill_len_nxt;
      r_flush_sector  <= w_flush_sector_nxt;
      r_flush_len     <= w_flush_len_nxt;
      r_overrun       <= w_overrun_nxt;
    end
  end

  assign o_flush_req    = (r_drain == DrainReq);
  assign o_busy         = (r_drain != DrainIdle);
  assign o_flush_sector = r_flush_sector;
  assign o_flush_len    = r_flush_len;
  assign o_overrun      = r_overrun;

  sector_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr_en   (i_wr_en),
    .i_wr_bank (r_wr_bank),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_bank (w_rd_bank),
    .i_rd_addr (i_rd_addr),
    .o_rd_data (o_rd_data)
  );

endmodule
